mag_readout_gpio: RTL and testbench

MAG_READOUT_GPIO -- requirements
Module: mag_readout_gpio

---
 rtl/mag_readout_pkg.sv | 19 +
 rtl/mag_readout_gpio_if.sv | 32 +++
 rtl/mag_readout_word_sel.sv | 31 +++
 rtl/mag_readout_gpio.sv | 172 +++++++++++++++++
 tb/tb_mag_readout_gpio.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/mag_readout_pkg.sv
// mag_readout_pkg -- shared types and constants for the magnitude GPIO readout block.
//   state_e          : readout FSM state (idle / reading a snapshot)
//   Status*Bit/Lsb   : bit positions inside the gpioStatus word
//   SampleCountWidth : width of the wrapping sample counter reported in gpioStatus
package mag_readout_pkg;

   typedef enum logic [0:0] {
      StIdle    = 1'b0,
      StReading = 1'b1
   } state_e;

   localparam int unsigned StatusReadingBit = 0;
   localparam int unsigned StatusFreshBit   = 1;
   localparam int unsigned StatusValidBit   = 2;
   localparam int unsigned StatusCountLsb   = 16;

   localparam int unsigned SampleCountWidth = 16;

endpackage

// File: rtl/mag_readout_gpio_if.sv
// mag_readout_gpio_if -- sample input and processor GPIO signals of mag_readout_gpio.
//   trimmedStrobe  : one-cycle sample-valid pulse
//   trimmed        : NUM_MAGS packed magnitudes, index 0 in the LSBs
//   gpioLatch      : processor snapshot request
//   gpioReadStrobe : processor word-advance pulse
//   gpioData       : current readout word (registered)
//   gpioStatus     : status word (registered)
// Modports: master = sample source / processor side, slave = readout block.
interface mag_readout_gpio_if #(
   parameter int unsigned GPIO_WIDTH = 32,
   parameter int unsigned NUM_MAGS   = 4,
   parameter int unsigned MAG_WIDTH  = 26
);

   logic                          trimmedStrobe;
   logic [MAG_WIDTH*NUM_MAGS-1:0] trimmed;
   logic                          gpioLatch;
   logic                          gpioReadStrobe;
   logic [GPIO_WIDTH-1:0]         gpioData;
   logic [GPIO_WIDTH-1:0]         gpioStatus;

   modport master (
      output trimmedStrobe, trimmed, gpioLatch, gpioReadStrobe,
      input  gpioData, gpioStatus
   );

   modport slave (
      input  trimmedStrobe, trimmed, gpioLatch, gpioReadStrobe,
      output gpioData, gpioStatus
   );

endinterface

// File: rtl/mag_readout_word_sel.sv
// mag_readout_word_sel -- picks one readout word and zero-extends it to GPIO_WIDTH.
//   mags : packed magnitudes, index 0 in the LSBs
//   ts   : timestamp word, selected at index NUM_MAGS when HAS_TS is set
//   idx  : word index
//   word : selected word; out-of-range indices give 0
module mag_readout_word_sel #(
   parameter int unsigned GPIO_WIDTH = 32,
   parameter int unsigned NUM_MAGS   = 4,
   parameter int unsigned MAG_WIDTH  = 26,
   parameter bit          HAS_TS     = 1'b0,
   parameter int unsigned IDX_WIDTH  = 2
) (
   input  logic [MAG_WIDTH*NUM_MAGS-1:0] mags,
   input  logic [GPIO_WIDTH-1:0]         ts,
   input  logic [IDX_WIDTH-1:0]          idx,
   output logic [GPIO_WIDTH-1:0]         word
);

   always_comb begin
      word = '0;
      for (int i = 0; i < NUM_MAGS; i++) begin
         if (idx == IDX_WIDTH'(i)) begin
            word[MAG_WIDTH-1:0] = mags[i*MAG_WIDTH +: MAG_WIDTH];
         end
      end
      if (HAS_TS && (idx == IDX_WIDTH'(NUM_MAGS))) begin
         word = ts;
      end
   end

endmodule

// File: rtl/mag_readout_gpio.sv
// mag_readout_gpio -- atomic processor readout of trimmed magnitude samples over GPIO.
// Every trimmedStrobe loads a shadow copy of the sample and bumps a 16-bit wrapping
// sample count. gpioLatch freezes the shadow into a snapshot that the processor then
// walks one word per gpioReadStrobe; new samples never disturb a readout in progress.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : mag_readout_gpio_if.slave (trimmedStrobe, trimmed, gpioLatch,
//           gpioReadStrobe in; gpioData, gpioStatus out)
// Build option MAG_READOUT_TIMESTAMP_EN: adds a free-running cycle counter captured
// with each sample and read back as an extra word after the magnitudes.
module mag_readout_gpio
   import mag_readout_pkg::*;
#(
   parameter int unsigned GPIO_WIDTH = 32,
   parameter int unsigned NUM_MAGS   = 4,
   parameter int unsigned MAG_WIDTH  = 26
) (
   input logic               clk,
   input logic               rst_n,
   mag_readout_gpio_if.slave bus
);

   localparam int unsigned TotWidth = MAG_WIDTH * NUM_MAGS;
`ifdef MAG_READOUT_TIMESTAMP_EN
   localparam bit          HasTs    = 1'b1;
`else
   localparam bit          HasTs    = 1'b0;
`endif
   localparam int unsigned NumWords = NUM_MAGS + (HasTs ? 1 : 0);
   localparam int unsigned IdxWidth = (NumWords > 1) ? $clog2(NumWords) : 1;
   localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumWords - 1);

   if (GPIO_WIDTH < 32) begin : g_err_gpio_width
      $error("mag_readout_gpio: GPIO_WIDTH must be at least 32");
   end
   if (MAG_WIDTH > GPIO_WIDTH) begin : g_err_mag_width
      $error("mag_readout_gpio: MAG_WIDTH must not exceed GPIO_WIDTH");
   end
   if (NUM_MAGS < 1) begin : g_err_num_mags
      $error("mag_readout_gpio: NUM_MAGS must be at least 1");
   end

   state_e                      state_q, state_next;
   logic [TotWidth-1:0]         shadow_q, shadow_next;
   logic [TotWidth-1:0]         snap_q;
   logic [SampleCountWidth-1:0] sample_cnt_q, sample_cnt_next;
   logic [SampleCountWidth-1:0] snap_cnt_q, snap_cnt_next;
   logic [IdxWidth-1:0]         idx_q, idx_next;
   logic                        fresh_q, fresh_next;
   logic                        valid_q, valid_next;
   logic [GPIO_WIDTH-1:0]       data_q;
   logic [GPIO_WIDTH-1:0]       status_q, status_next;

   logic                        load_data;
   logic [TotWidth-1:0]         sel_mags;
   logic [GPIO_WIDTH-1:0]       sel_ts;
   logic [IdxWidth-1:0]         sel_idx;
   logic [GPIO_WIDTH-1:0]       sel_word;

`ifdef MAG_READOUT_TIMESTAMP_EN
   logic [GPIO_WIDTH-1:0] ts_cnt_q;
   logic [GPIO_WIDTH-1:0] shadow_ts_q, shadow_ts_next;
   logic [GPIO_WIDTH-1:0] snap_ts_q;

   assign shadow_ts_next = bus.trimmedStrobe ? ts_cnt_q : shadow_ts_q;
   // A latch reads from the (possibly just-updated) shadow, otherwise the frozen snapshot.
   assign sel_ts         = bus.gpioLatch ? shadow_ts_next : snap_ts_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts_cnt_q    <= '0;
         shadow_ts_q <= '0;
         snap_ts_q   <= '0;
      end else begin
         ts_cnt_q    <= ts_cnt_q + GPIO_WIDTH'(1);
         shadow_ts_q <= shadow_ts_next;
         if (bus.gpioLatch) begin
            snap_ts_q <= shadow_ts_next;
         end
      end
   end
`else
   assign sel_ts = '0;
`endif

   always_comb begin
      shadow_next     = bus.trimmedStrobe ? bus.trimmed : shadow_q;
      sample_cnt_next = sample_cnt_q + SampleCountWidth'(bus.trimmedStrobe);

      state_next = state_q;
      idx_next   = idx_q;
      load_data  = 1'b0;
      sel_mags   = snap_q;
      sel_idx    = idx_q;

      // Latch wins over a simultaneous read strobe and is honoured in any state.
      if (bus.gpioLatch) begin
         state_next = StReading;
         idx_next   = '0;
         sel_mags   = shadow_next;
         sel_idx    = '0;
         load_data  = 1'b1;
      end else if ((state_q == StReading) && bus.gpioReadStrobe) begin
         if (idx_q == LastIdx) begin
            // Readout done: gpioData keeps showing the last word.
            state_next = StIdle;
            idx_next   = '0;
         end else begin
            idx_next  = idx_q + IdxWidth'(1);
            sel_idx   = idx_next;
            load_data = 1'b1;
         end
      end

      fresh_next    = !bus.gpioLatch && (fresh_q || bus.trimmedStrobe);
      valid_next    = valid_q || bus.trimmedStrobe;
      snap_cnt_next = bus.gpioLatch ? sample_cnt_next : snap_cnt_q;

      status_next                                       = '0;
      status_next[StatusReadingBit]                     = (state_next == StReading);
      status_next[StatusFreshBit]                       = fresh_next;
      status_next[StatusValidBit]                       = valid_next;
      status_next[StatusCountLsb +: SampleCountWidth]   = snap_cnt_next;
   end

   mag_readout_word_sel #(
      .GPIO_WIDTH (GPIO_WIDTH),
      .NUM_MAGS   (NUM_MAGS),
      .MAG_WIDTH  (MAG_WIDTH),
      .HAS_TS     (HasTs),
      .IDX_WIDTH  (IdxWidth)
   ) u_word_sel (
      .mags (sel_mags),
      .ts   (sel_ts),
      .idx  (sel_idx),
      .word (sel_word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         shadow_q     <= '0;
         snap_q       <= '0;
         sample_cnt_q <= '0;
         snap_cnt_q   <= '0;
         idx_q        <= '0;
         fresh_q      <= 1'b0;
         valid_q      <= 1'b0;
         data_q       <= '0;
         status_q     <= '0;
      end else begin
         state_q      <= state_next;
         shadow_q     <= shadow_next;
         sample_cnt_q <= sample_cnt_next;
         snap_cnt_q   <= snap_cnt_next;
         idx_q        <= idx_next;
         fresh_q      <= fresh_next;
         valid_q      <= valid_next;
         status_q     <= status_next;
         if (bus.gpioLatch) begin
            snap_q <= shadow_next;
         end
         if (load_data) begin
            data_q <= sel_word;
         end
      end
   end

   assign bus.gpioData   = data_q;
   assign bus.gpioStatus = status_q;

endmodule

// File: tb/tb_mag_readout_gpio.sv
// tb_mag_readout_gpio -- directed bench for mag_readout_gpio with a scoreboard queue:
// each step pushes the expected gpioData/gpioStatus, drives one clock, then pops and
// compares one time unit after the edge.
module tb_mag_readout_gpio;

   localparam int unsigned GW = 32;
   localparam int unsigned NM = 4;
   localparam int unsigned MW = 26;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   mag_readout_gpio_if #(.GPIO_WIDTH(GW), .NUM_MAGS(NM), .MAG_WIDTH(MW)) bus ();

   mag_readout_gpio #(
      .GPIO_WIDTH (GW),
      .NUM_MAGS   (NM),
      .MAG_WIDTH  (MW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      string       tag;
      logic [31:0] exp;
      bit          is_status;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic logic [NM*MW-1:0] pack4(input logic [MW-1:0] m0, input logic [MW-1:0] m1,
                                              input logic [MW-1:0] m2, input logic [MW-1:0] m3);
      return {m3, m2, m1, m0};
   endfunction

   task automatic expect_out(input string tag, input logic [31:0] data, input logic [31:0] stat);
      exp_t e;
      e.tag = {tag, ".data"};   e.exp = data; e.is_status = 1'b0; sb.push_back(e);
      e.tag = {tag, ".status"}; e.exp = stat; e.is_status = 1'b1; sb.push_back(e);
   endtask

   task automatic check_all();
      exp_t        e;
      logic [31:0] obs;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = e.is_status ? bus.gpioStatus : bus.gpioData;
         n_tests++;
         assert (obs === e.exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", e.tag, obs, e.exp);
         end
      end
   endtask

   // Called at posedge+1; drives one clock of inputs, then checks at the next posedge+1.
   task automatic step(input bit ts, input logic [NM*MW-1:0] tv, input bit lat, input bit rd);
      bus.trimmedStrobe  = ts;
      bus.trimmed        = tv;
      bus.gpioLatch      = lat;
      bus.gpioReadStrobe = rd;
      @(posedge clk);
      #1;
      bus.trimmedStrobe  = 1'b0;
      bus.gpioLatch      = 1'b0;
      bus.gpioReadStrobe = 1'b0;
      check_all();
   endtask

   logic [NM*MW-1:0] t1, t2, t3, z;

   initial begin
      t1 = pack4(26'h3FFFFFF, 26'd1, 26'd2, 26'd3);
      t2 = pack4(26'd4, 26'd5, 26'd6, 26'd7);
      t3 = pack4(26'h155, 26'h11, 26'h22, 26'h33);
      z  = '0;
      bus.trimmedStrobe  = 1'b0;
      bus.trimmed        = '0;
      bus.gpioLatch      = 1'b0;
      bus.gpioReadStrobe = 1'b0;

      #12;
      expect_out("reset", 32'h0, 32'h0);
      check_all();
      rst_n = 1'b1;
      @(posedge clk);
      #1;

`ifdef MAG_READOUT_TIMESTAMP_EN
      // One edge has passed since release; 99 more put the cycle counter at 100.
      repeat (99) step(1'b0, z, 1'b0, 1'b0);
      expect_out("ts.sample", 32'h0, 32'h0000_0006);
      step(1'b1, t1, 1'b0, 1'b0);
      expect_out("ts.w0", 32'h03FF_FFFF, 32'h0001_0005); step(1'b0, z, 1'b1, 1'b0);
      expect_out("ts.w1", 32'd1, 32'h0001_0005);         step(1'b0, z, 1'b0, 1'b1);
      expect_out("ts.w2", 32'd2, 32'h0001_0005);         step(1'b0, z, 1'b0, 1'b1);
      expect_out("ts.w3", 32'd3, 32'h0001_0005);         step(1'b0, z, 1'b0, 1'b1);
      expect_out("ts.w4", 32'd100, 32'h0001_0005);       step(1'b0, z, 1'b0, 1'b1);
      expect_out("ts.end", 32'd100, 32'h0001_0004);      step(1'b0, z, 1'b0, 1'b1);
`else
      // Basic readout.
      expect_out("s1.sample", 32'h0, 32'h0000_0006);     step(1'b1, t1, 1'b0, 1'b0);
      expect_out("s1.w0", 32'h03FF_FFFF, 32'h0001_0005); step(1'b0, z, 1'b1, 1'b0);
      expect_out("s1.w1", 32'd1, 32'h0001_0005);         step(1'b0, z, 1'b0, 1'b1);
      expect_out("s1.w2", 32'd2, 32'h0001_0005);         step(1'b0, z, 1'b0, 1'b1);
      expect_out("s1.w3", 32'd3, 32'h0001_0005);         step(1'b0, z, 1'b0, 1'b1);
      expect_out("s1.end", 32'd3, 32'h0001_0004);        step(1'b0, z, 1'b0, 1'b1);

      // New sample mid-readout leaves the snapshot alone.
      expect_out("s2.w0", 32'h03FF_FFFF, 32'h0001_0005); step(1'b0, z, 1'b1, 1'b0);
      expect_out("s2.w1", 32'd1, 32'h0001_0005);         step(1'b0, z, 1'b0, 1'b1);
      expect_out("s2.newsmp", 32'd1, 32'h0001_0007);     step(1'b1, t2, 1'b0, 1'b0);
      expect_out("s2.w2", 32'd2, 32'h0001_0007);         step(1'b0, z, 1'b0, 1'b1);
      expect_out("s2.w3", 32'd3, 32'h0001_0007);         step(1'b0, z, 1'b0, 1'b1);
      expect_out("s2.end", 32'd3, 32'h0001_0006);        step(1'b0, z, 1'b0, 1'b1);

      // Latch and sample together: incoming value, count 3, fresh cleared.
      expect_out("s3.w0", 32'h155, 32'h0003_0005);       step(1'b1, t3, 1'b1, 1'b0);
      expect_out("s3.w1", 32'h11, 32'h0003_0005);        step(1'b0, z, 1'b0, 1'b1);
      expect_out("s3.w2", 32'h22, 32'h0003_0005);        step(1'b0, z, 1'b0, 1'b1);
      expect_out("s3.w3", 32'h33, 32'h0003_0005);        step(1'b0, z, 1'b0, 1'b1);
      expect_out("s3.end", 32'h33, 32'h0003_0004);       step(1'b0, z, 1'b0, 1'b1);

      // Read in IDLE is ignored; latch beats a simultaneous read.
      expect_out("s4.idlerd", 32'h33, 32'h0003_0004);    step(1'b0, z, 1'b0, 1'b1);
      expect_out("s4.w0", 32'h155, 32'h0003_0005);       step(1'b0, z, 1'b1, 1'b0);
      expect_out("s4.w1", 32'h11, 32'h0003_0005);        step(1'b0, z, 1'b0, 1'b1);
      expect_out("s4.w2", 32'h22, 32'h0003_0005);        step(1'b0, z, 1'b0, 1'b1);
      expect_out("s4.both", 32'h155, 32'h0003_0005);     step(1'b0, z, 1'b1, 1'b1);
      expect_out("s4.rw1", 32'h11, 32'h0003_0005);       step(1'b0, z, 1'b0, 1'b1);
      expect_out("s4.rw2", 32'h22, 32'h0003_0005);       step(1'b0, z, 1'b0, 1'b1);

      // Asynchronous reset in the middle of word 2.
      #2;
      rst_n = 1'b0;
      #1;
      expect_out("s6.rst", 32'h0, 32'h0);
      check_all();
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      expect_out("s6.idlerd", 32'h0, 32'h0);             step(1'b0, z, 1'b0, 1'b1);
      expect_out("s6.latch0", 32'h0, 32'h0000_0001);     step(1'b0, z, 1'b1, 1'b0);

      // 65537 samples wrap the 16-bit count to 1; snapshot stays put meanwhile.
      bus.trimmed       = t1;
      bus.trimmedStrobe = 1'b1;
      repeat (65537) @(posedge clk);
      #1;
      bus.trimmedStrobe = 1'b0;
      expect_out("s5.held", 32'h0, 32'h0000_0007);
      check_all();
      expect_out("s5.wrap", 32'h03FF_FFFF, 32'h0001_0005); step(1'b0, z, 1'b1, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
